param_stack: RTL
================

Name: param_stack

Overview:
- Parametrised LIFO stack for the RISC processor; successor to the fixed 32x32 stack.
- Used for call/return address save and general push/pop operand storage.
- Adds over the previous stack: configurable width/depth, full use of all DEPTH entries, count/full/empty status, same-cycle push+pop (replace top), sticky overflow/underflow error flags, and a read-valid strobe.

Parameters:
DATA_W, 32, width of each stack entry in bits
DEPTH, 32, number of entries; any value >= 2 (need not be a power of 2)
PTR_W, $clog2(DEPTH+1), width of pointer/count; derived, not to be overridden

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
push  in  1  write data_in onto stack this cycle
pop  in  1  remove top entry this cycle
data_in  in  DATA_W  data to push
clr_err  in  1  clears overflow/underflow flags
data_out  out  DATA_W  registered popped value
rd_valid  out  1  one-cycle pulse: data_out updated by a successful pop
count  out  PTR_W  entries currently held, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: push attempted while full (without pop)
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high.
- Reset:
  - count=0, empty=1, full=0, data_out=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset wins over all other inputs in the same cycle, including mid push/pop.
- Internal state: ptr (= count) indexes the next free slot; top entry is mem[ptr-1].
- Each cycle, decode {push,pop} into one operation:
  - NOP (0,0): nothing changes; rd_valid=0.
  - PUSH (1,0), not full: mem[ptr]<=data_in, ptr+1.
  - PUSH, full: ignored; overflow<=1; contents and count unchanged.
  - POP (0,1), not empty: data_out<=mem[ptr-1], rd_valid<=1 next cycle, ptr-1.
  - POP, empty: ignored; underflow<=1; data_out holds; rd_valid=0.
  - REPLACE (1,1), not empty (including full):
    - data_out<=old top; rd_valid<=1; mem[ptr-1]<=data_in; count unchanged.
    - No overflow is flagged, even when full.
  - REPLACE (1,1), empty: acts as PUSH of data_in (count 0->1); underflow<=1; rd_valid=0.
- Latency: a popped value appears on data_out one cycle after the pop edge, together with rd_valid.
- Pushed data is poppable on the very next cycle (no bubble).
- Status outputs:
  - count, full and empty are registered and consistent with ptr after each edge.
  - No wrap-around: ptr saturates at 0 and DEPTH by the ignore rules above.
- Error flags:
  - Sticky until clr_err=1 or reset.
  - If clr_err coincides with a new error event, the new event wins (flag stays 1).
- data_out holds its last value between pops.

Optional Feature:
- Macro: PARAM_STACK_PEEK_EN.
- Defined:
  - Adds output peek_data [DATA_W] and peek_valid [1].
  - peek_data is a registered copy of the current top entry, updated every edge to reflect post-operation state (top after push/pop/replace); peek_valid = !empty.
  - Lets the pipeline read the return address without popping.
- Undefined: ports absent; no peek register logic.

Decomposition:
- Package stack_pkg:
  - stack_op_t enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE}.
  - Function decode_op(push,pop).
  - Default DATA_W/DEPTH constants.
- Sub-module stack_mem:
  - DEPTH x DATA_W register array.
  - One synchronous write port, one asynchronous read port at address ptr-1.
  - Keeps storage separate from pointer/flag control in param_stack.

Test Plan:
- Reset then push 0xA, 0xB, 0xC -> count=3; then three pops -> data_out 0xC, 0xB, 0xA, each with rd_valid pulse one cycle after its pop; empty=1 at end.
- DEPTH=4: push 5 values 1..5 -> full=1 after 4th, overflow=1 after 5th; pop all -> 4,3,2,1 (5 never stored).
- From empty, pop -> underflow=1, rd_valid=0, data_out unchanged; clr_err -> underflow=0; clr_err with simultaneous empty pop -> underflow stays 1.
- Stack [0x10,0x20], push+pop with 0x99 -> data_out=0x20, count=2; next pop -> 0x99. Same on a full stack -> overflow stays 0.
- Push+pop on empty with 0x7 -> count=1, underflow=1; pop -> data_out=0x7.
- Assert reset during a push of 0x55 with count=2 -> count=0, all outputs at reset values, no rd_valid. With PARAM_STACK_PEEK_EN: after pushes 0x1, 0x2, peek_data=0x2, peek_valid=1, count unchanged.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and defaults for the parametrised LIFO stack.
// Operation decode used by param_stack; default geometry constants.
package stack_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_PUSH,
      OP_POP,
      OP_REPLACE
   } stack_op_t;

   // Collapse the two request strobes into a single operation code
   function automatic stack_op_t decode_op(input logic push, input logic pop);
      stack_op_t op;
      case ({push, pop})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_REPLACE;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write
// port and one asynchronous read port (top of stack). With
// PARAM_STACK_PEEK_EN defined a second async read port exposes the entry
// below the top so the controller can refresh its peek register on a pop.
module stack_mem #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
`ifdef PARAM_STACK_PEEK_EN
   ,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
`endif
);

   // Contents are deliberately left uninitialised; reset does not clear them
   logic [DATA_W-1:0] mem_q [DEPTH];

   // Single write port; the controller never addresses beyond DEPTH-1
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

`ifdef PARAM_STACK_PEEK_EN
   assign rdata2 = mem_q[raddr2];
`endif

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack: push/pop/replace control, count/full/empty
// status, sticky overflow/underflow flags and a registered pop output.
// Optional feature macro: PARAM_STACK_PEEK_EN (adds peek_data/peek_valid,
// a registered copy of the post-operation top entry).
module param_stack
   import stack_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int PTR_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic              clr_err,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic [PTR_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
`ifdef PARAM_STACK_PEEK_EN
   ,
   output logic [DATA_W-1:0] peek_data,
   output logic              peek_valid
`endif
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0]  ONE_P   = 1;
   localparam logic [ADDR_W-1:0] ONE_A   = 1;

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   stack_op_t         op;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] top_data;

`ifdef PARAM_STACK_PEEK_EN
   logic [DATA_W-1:0] peek_q, peek_d;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] below_data;
`endif

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk    (clk),
      .we     (we),
      .waddr  (waddr),
      .wdata  (data_in),
      .raddr  (raddr),
      .rdata  (top_data)
`ifdef PARAM_STACK_PEEK_EN
      ,
      .raddr2 (raddr2),
      .rdata2 (below_data)
`endif
   );

   // Decode the request, compute next pointer/flags and the memory write
   always_comb begin
      op         = decode_op(push, pop);
      // Top lives at ptr-1; park the address at 0 when empty to stay in range
      raddr      = empty_q ? '0 : ptr_q[ADDR_W-1:0] - ONE_A;
      waddr      = ptr_q[ADDR_W-1:0];
      we         = 1'b0;
      ptr_d      = ptr_q;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      // A new error event in the same cycle as clr_err keeps the flag set
      ovf_d      = ovf_q & ~clr_err;
      udf_d      = udf_q & ~clr_err;
      case (op)
         OP_PUSH: begin
            if (full_q) begin
               ovf_d = 1'b1;
            end else begin
               we    = 1'b1;
               ptr_d = ptr_q + ONE_P;
            end
         end
         OP_POP: begin
            if (empty_q) begin
               udf_d = 1'b1;
            end else begin
               data_out_d = top_data;
               rd_valid_d = 1'b1;
               ptr_d      = ptr_q - ONE_P;
            end
         end
         OP_REPLACE: begin
            if (empty_q) begin
               // Nothing to pop: behaves as a push into slot 0
               we    = 1'b1;
               ptr_d = ONE_P;
               udf_d = 1'b1;
            end else begin
               // Old top is read before the edge, then overwritten in place
               data_out_d = top_data;
               rd_valid_d = 1'b1;
               we         = 1'b1;
               waddr      = raddr;
            end
         end
         default: ;
      endcase
      // Reset takes precedence over any write in flight
      if (reset) we = 1'b0;
      full_d  = (ptr_d == DEPTH_P);
      empty_d = (ptr_d == '0);
   end

`ifdef PARAM_STACK_PEEK_EN
   // Track the post-operation top: new data on push/replace, the entry
   // below the old top on a pop that leaves the stack non-empty
   always_comb begin
      raddr2 = (ptr_q > ONE_P) ? raddr - ONE_A : '0;
      peek_d = peek_q;
      case (op)
         OP_PUSH:    if (!full_q) peek_d = data_in;
         OP_POP:     if (ptr_q > ONE_P) peek_d = below_data;
         OP_REPLACE: peek_d = data_in;
         default: ;
      endcase
   end
`endif

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
`ifdef PARAM_STACK_PEEK_EN
         peek_q     <= '0;
`endif
      end else begin
         ptr_q      <= ptr_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
`ifdef PARAM_STACK_PEEK_EN
         peek_q     <= peek_d;
`endif
      end
   end

   assign data_out  = data_out_q;
   assign rd_valid  = rd_valid_q;
   assign count     = ptr_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

`ifdef PARAM_STACK_PEEK_EN
   assign peek_data  = peek_q;
   assign peek_valid = ~empty_q;
`endif

endmodule
